// File: rtl/alu_result_writeback.sv
// Post-ALU writeback stage: captures the ALU result and flags, then steers the result
// to the register file, the PC, or a data-memory request/acknowledge transaction.
module alu_result_writeback (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] alu_out,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        alu_carry,
    input  logic [1:0]  c_dest,
    input  logic        c_mem_write,
    input  logic [1:0]  c_cond,
    input  logic [1:0]  c_reg_src,
    input  logic [3:0]  c_wr_reg,
    input  logic [7:0]  imm8,
    input  logic [15:0] pc_in,
    input  logic [15:0] store_data,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        reg_we,
    output logic [3:0]  reg_waddr,
    output logic [15:0] reg_wdata,
    output logic        pc_we,
    output logic [15:0] pc_next,
    output logic [2:0]  flags,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MEM,
        LOADWB
    } state_t;

    state_t      state_q,     state_d;
    logic [15:0] aluout_q,    aluout_d;
    logic [15:0] mdr_q,       mdr_d;
    logic [2:0]  flags_q,     flags_d;
    logic [1:0]  dest_q,      dest_d;
    logic        mem_write_q, mem_write_d;
    logic [3:0]  wr_reg_q,    wr_reg_d;
    logic [15:0] store_q,     store_d;
    logic        mem_req_q,   mem_req_d;
    logic        mem_we_q,    mem_we_d;
    logic [15:0] mem_addr_q,  mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        reg_we_q,    reg_we_d;
    logic [3:0]  reg_waddr_q, reg_waddr_d;
    logic [15:0] reg_wdata_q, reg_wdata_d;
    logic        pc_we_q,     pc_we_d;
    logic [15:0] pc_next_q,   pc_next_d;
    logic        done_q,      done_d;

    logic [15:0] src_data;
    logic        branch_taken;

    always_comb begin
        src_data = alu_out;
        unique case (c_reg_src)
            2'b00: src_data = alu_out;
            2'b01: src_data = mdr_q;
            2'b10: src_data = {imm8, 8'h00};
            2'b11: src_data = pc_in;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        unique case (c_cond)
            2'b00: branch_taken = alu_zero;
            2'b01: branch_taken = !alu_zero;
            2'b10: branch_taken = alu_neg;
            2'b11: branch_taken = !alu_neg;
        endcase
    end

    // EXEC strobes are registered on the IDLE->EXEC edge from the live inputs, so they
    // appear in the EXEC cycle itself; only what MEM/LOADWB need is kept in holding regs.
    always_comb begin
        state_d     = state_q;
        aluout_d    = aluout_q;
        mdr_d       = mdr_q;
        flags_d     = flags_q;
        dest_d      = dest_q;
        mem_write_d = mem_write_q;
        wr_reg_d    = wr_reg_q;
        store_d     = store_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        reg_we_d    = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        pc_we_d     = 1'b0;
        pc_next_d   = pc_next_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = EXEC;
                    aluout_d    = alu_out;
                    flags_d     = {alu_carry, alu_neg, alu_zero};
                    dest_d      = c_dest;
                    mem_write_d = c_mem_write;
                    wr_reg_d    = c_wr_reg;
                    store_d     = store_data;
                    unique case (c_dest)
                        2'b00: begin
                            reg_we_d    = 1'b1;
                            reg_waddr_d = c_wr_reg;
                            reg_wdata_d = src_data;
                            done_d      = 1'b1;
                        end
                        2'b01: begin
                            pc_we_d   = 1'b1;
                            pc_next_d = alu_out;
                            done_d    = 1'b1;
                        end
                        2'b10: begin
                            if (branch_taken) begin
                                pc_we_d   = 1'b1;
                                pc_next_d = alu_out;
                            end
                            done_d = 1'b1;
                        end
                        2'b11: begin
                        end
                    endcase
                end
            end
            EXEC: begin
                if (dest_q == 2'b11) begin
                    state_d     = MEM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = mem_write_q;
                    mem_addr_d  = aluout_q;
                    mem_wdata_d = store_q;
                end else begin
                    state_d = IDLE;
                end
            end
            MEM: begin
                if (mem_ack) begin
                    if (mem_we_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = LOADWB;
                        mdr_d       = mem_rdata;
                        reg_we_d    = 1'b1;
                        reg_waddr_d = wr_reg_q;
                        reg_wdata_d = mem_rdata;
                        done_d      = 1'b1;
                    end
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = mem_we_q;
                end
            end
            LOADWB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            aluout_q    <= '0;
            mdr_q       <= '0;
            flags_q     <= '0;
            dest_q      <= '0;
            mem_write_q <= 1'b0;
            wr_reg_q    <= '0;
            store_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            pc_we_q     <= 1'b0;
            pc_next_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            aluout_q    <= aluout_d;
            mdr_q       <= mdr_d;
            flags_q     <= flags_d;
            dest_q      <= dest_d;
            mem_write_q <= mem_write_d;
            wr_reg_q    <= wr_reg_d;
            store_q     <= store_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            pc_we_q     <= pc_we_d;
            pc_next_q   <= pc_next_d;
            done_q      <= done_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;
    assign pc_we     = pc_we_q;
    assign pc_next   = pc_next_q;
    assign flags     = flags_q;
    assign busy      = (state_q != IDLE);
    // A store completes in the very cycle its acknowledge arrives.
    assign done      = done_q | ((state_q == MEM) && mem_ack && mem_we_q);

endmodule

// File: tb/tb_alu_result_writeback.sv
// Self-checking bench for alu_result_writeback: directed scenarios plus randomized
// operations compared against a transaction-level timing model.
module tb_alu_result_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] alu_out = '0;
    logic        alu_zero = 1'b0, alu_neg = 1'b0, alu_carry = 1'b0;
    logic [1:0]  c_dest = '0, c_cond = '0, c_reg_src = '0;
    logic        c_mem_write = 1'b0;
    logic [3:0]  c_wr_reg = '0;
    logic [7:0]  imm8 = '0;
    logic [15:0] pc_in = '0, store_data = '0, mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, reg_we, pc_we, busy, done;
    logic [15:0] mem_addr, mem_wdata, reg_wdata, pc_next;
    logic [3:0]  reg_waddr;
    logic [2:0]  flags;

    int checks = 0;
    int errors = 0;
    logic [15:0] mdr_m;

    always #5 clk = ~clk;

    alu_result_writeback dut (
        .clk(clk), .rst(rst), .start(start), .alu_out(alu_out),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry),
        .c_dest(c_dest), .c_mem_write(c_mem_write), .c_cond(c_cond),
        .c_reg_src(c_reg_src), .c_wr_reg(c_wr_reg), .imm8(imm8), .pc_in(pc_in),
        .store_data(store_data), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .pc_we(pc_we), .pc_next(pc_next), .flags(flags), .busy(busy), .done(done)
    );

    typedef struct packed {
        int          reg_cnt;
        int          reg_cyc;
        logic [3:0]  waddr;
        logic [15:0] wdata;
        int          pc_cnt;
        int          pc_cyc;
        logic [15:0] pcv;
        int          done_cnt;
        int          done_cyc;
        int          req_cnt;
        int          req_first;
        logic [15:0] maddr;
        logic        mwe;
        logic [15:0] mwdata;
        logic        req_unstable;
        logic        busy_after;
        logic [2:0]  flags_end;
    } obs_t;

    // Expected outcome of one operation; cycle 1 is the cycle after start is sampled.
    function automatic obs_t model(input logic [1:0] dest, input logic mw, input logic [1:0] cond,
                                   input logic [1:0] src, input logic [3:0] wr, input logic [7:0] im,
                                   input logic [15:0] pc, input logic [15:0] sd, input logic [15:0] alu,
                                   input logic [2:0] fl, input int delay, input logic [15:0] rdata,
                                   input logic [15:0] mdr);
        obs_t e;
        bit   taken;
        e = '0;
        e.done_cnt = 1;
        e.flags_end = fl;
        if (dest == 2'd0) begin
            e.reg_cnt = 1; e.reg_cyc = 1; e.waddr = wr; e.done_cyc = 1;
            if (src == 2'd0)      e.wdata = alu;
            else if (src == 2'd1) e.wdata = mdr;
            else if (src == 2'd2) e.wdata = 16'(im) * 16'd256;
            else                  e.wdata = pc;
        end else if (dest == 2'd1) begin
            e.pc_cnt = 1; e.pc_cyc = 1; e.pcv = alu; e.done_cyc = 1;
        end else if (dest == 2'd2) begin
            if (cond == 2'd0)      taken = fl[0];
            else if (cond == 2'd1) taken = !fl[0];
            else if (cond == 2'd2) taken = fl[1];
            else                   taken = !fl[1];
            if (taken) begin e.pc_cnt = 1; e.pc_cyc = 1; e.pcv = alu; end
            e.done_cyc = 1;
        end else begin
            e.req_cnt = delay; e.req_first = 2; e.maddr = alu; e.mwe = mw; e.mwdata = sd;
            if (mw) e.done_cyc = 1 + delay;
            else begin
                e.reg_cnt = 1; e.reg_cyc = 2 + delay; e.waddr = wr; e.wdata = rdata;
                e.done_cyc = 2 + delay;
            end
        end
        return e;
    endfunction

    // Runs one operation and records what the DUT did, cycle by cycle.
    task automatic do_op(input logic [1:0] dest, input logic mw, input logic [1:0] cond,
                         input logic [1:0] src, input logic [3:0] wr, input logic [7:0] im,
                         input logic [15:0] pc, input logic [15:0] sd, input logic [15:0] alu,
                         input logic [2:0] fl, input int delay, input logic [15:0] rdata,
                         input bit extra_start, output obs_t o);
        o = '0;
        @(posedge clk); #1;
        start = 1'b1; c_dest = dest; c_mem_write = mw; c_cond = cond; c_reg_src = src;
        c_wr_reg = wr; imm8 = im; pc_in = pc; store_data = sd; alu_out = alu;
        {alu_carry, alu_neg, alu_zero} = fl; mem_ack = 1'b0;
        #1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            start = extra_start && (k == 2);
            alu_out = 16'($urandom); {alu_carry, alu_neg, alu_zero} = 3'($urandom);
            c_dest = 2'($urandom); c_mem_write = 1'($urandom); c_cond = 2'($urandom);
            c_reg_src = 2'($urandom); c_wr_reg = 4'($urandom); imm8 = 8'($urandom);
            pc_in = 16'($urandom); store_data = 16'($urandom);
            mem_ack = 1'b0; mem_rdata = 16'($urandom);
            if (mem_req && (o.req_cnt + 1 == delay)) begin mem_ack = 1'b1; mem_rdata = rdata; end
            #1;
            if (mem_req) begin
                if (o.req_cnt == 0) begin
                    o.req_first = k; o.maddr = mem_addr; o.mwe = mem_we; o.mwdata = mem_wdata;
                end else if (mem_addr !== o.maddr || mem_we !== o.mwe || mem_wdata !== o.mwdata) begin
                    o.req_unstable = 1'b1;
                end
                o.req_cnt++;
            end
            if (reg_we) begin
                if (o.reg_cnt == 0) begin o.reg_cyc = k; o.waddr = reg_waddr; o.wdata = reg_wdata; end
                o.reg_cnt++;
            end
            if (pc_we) begin
                if (o.pc_cnt == 0) begin o.pc_cyc = k; o.pcv = pc_next; end
                o.pc_cnt++;
            end
            if (done) begin
                if (o.done_cnt == 0) o.done_cyc = k;
                o.done_cnt++;
            end
            if (o.done_cyc != 0 && k == o.done_cyc + 1) o.busy_after = busy;
            if (o.done_cyc != 0 && k == o.done_cyc + 2) break;
        end
        start = 1'b0; mem_ack = 1'b0;
        o.flags_end = flags;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        mdr_m = '0;
        checks++; if ({reg_we, pc_we, mem_req, mem_we, done, busy} !== 6'b0) begin errors++; $display("FAIL reset.strobes: got %b exp 000000", {reg_we, pc_we, mem_req, mem_we, done, busy}); end
        checks++; if (flags !== 3'b000) begin errors++; $display("FAIL reset.flags: got %b exp 000", flags); end
        checks++; if ({pc_next, reg_wdata, mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset.data: got %h exp 0", {pc_next, reg_wdata, mem_addr, mem_wdata}); end
        checks++; if (reg_waddr !== 4'h0) begin errors++; $display("FAIL reset.waddr: got %h exp 0", reg_waddr); end
    endtask

    task automatic test_reg_write;
        obs_t o;
        do_op(2'd0, 1'b0, 2'd0, 2'd0, 4'd5, 8'h00, 16'h0, 16'h0, 16'h1234, 3'b000, 1, 16'h0, 1'b0, o);
        checks++; if (o.reg_cnt !== 1 || o.reg_cyc !== 1) begin errors++; $display("FAIL reg_write.strobe: got cnt=%0d cyc=%0d exp cnt=1 cyc=1", o.reg_cnt, o.reg_cyc); end
        checks++; if (o.waddr !== 4'd5) begin errors++; $display("FAIL reg_write.waddr: got %h exp 5", o.waddr); end
        checks++; if (o.wdata !== 16'h1234) begin errors++; $display("FAIL reg_write.wdata: got %h exp 1234", o.wdata); end
        checks++; if (o.done_cnt !== 1 || o.done_cyc !== 1) begin errors++; $display("FAIL reg_write.done: got cnt=%0d cyc=%0d exp 1/1", o.done_cnt, o.done_cyc); end
        checks++; if (o.busy_after !== 1'b0) begin errors++; $display("FAIL reg_write.busy_t2: got %b exp 0", o.busy_after); end
        checks++; if (o.pc_cnt !== 0) begin errors++; $display("FAIL reg_write.pc_we: got %0d exp 0", o.pc_cnt); end
    endtask

    task automatic test_branch;
        obs_t o;
        do_op(2'd2, 1'b0, 2'd0, 2'd0, 4'd0, 8'h00, 16'h0, 16'h0, 16'h0040, 3'b001, 1, 16'h0, 1'b0, o);
        checks++; if (o.pc_cnt !== 1 || o.pc_cyc !== 1) begin errors++; $display("FAIL branch_taken.pc_we: got cnt=%0d cyc=%0d exp 1/1", o.pc_cnt, o.pc_cyc); end
        checks++; if (o.pcv !== 16'h0040) begin errors++; $display("FAIL branch_taken.pc_next: got %h exp 0040", o.pcv); end
        checks++; if (o.done_cyc !== 1) begin errors++; $display("FAIL branch_taken.done: got %0d exp 1", o.done_cyc); end
        do_op(2'd2, 1'b0, 2'd0, 2'd0, 4'd0, 8'h00, 16'h0, 16'h0, 16'h0040, 3'b000, 1, 16'h0, 1'b0, o);
        checks++; if (o.pc_cnt !== 0) begin errors++; $display("FAIL branch_not_taken.pc_we: got %0d exp 0", o.pc_cnt); end
        checks++; if (o.done_cnt !== 1 || o.done_cyc !== 1) begin errors++; $display("FAIL branch_not_taken.done: got cnt=%0d cyc=%0d exp 1/1", o.done_cnt, o.done_cyc); end
        checks++; if (o.flags_end !== 3'b000) begin errors++; $display("FAIL branch_not_taken.flags: got %b exp 000", o.flags_end); end
    endtask

    task automatic test_load;
        obs_t o;
        do_op(2'd3, 1'b0, 2'd0, 2'd0, 4'd3, 8'h00, 16'h0, 16'h0, 16'h0100, 3'b000, 3, 16'hBEEF, 1'b0, o);
        mdr_m = 16'hBEEF;
        checks++; if (o.req_cnt !== 3 || o.req_first !== 2) begin errors++; $display("FAIL load.mem_req: got cnt=%0d first=%0d exp 3/2", o.req_cnt, o.req_first); end
        checks++; if (o.maddr !== 16'h0100 || o.mwe !== 1'b0 || o.req_unstable !== 1'b0) begin errors++; $display("FAIL load.mem_addr: got %h we=%b unstable=%b exp 0100/0/0", o.maddr, o.mwe, o.req_unstable); end
        checks++; if (o.reg_cnt !== 1 || o.reg_cyc !== 5) begin errors++; $display("FAIL load.reg_we: got cnt=%0d cyc=%0d exp 1/5", o.reg_cnt, o.reg_cyc); end
        checks++; if (o.waddr !== 4'd3 || o.wdata !== 16'hBEEF) begin errors++; $display("FAIL load.writeback: got %h/%h exp 3/beef", o.waddr, o.wdata); end
        checks++; if (o.done_cnt !== 1 || o.done_cyc !== 5) begin errors++; $display("FAIL load.done: got cnt=%0d cyc=%0d exp 1/5", o.done_cnt, o.done_cyc); end
    endtask

    task automatic test_store;
        obs_t o;
        do_op(2'd3, 1'b1, 2'd0, 2'd0, 4'd9, 8'h00, 16'h0, 16'h00FF, 16'h0300, 3'b101, 1, 16'h1111, 1'b1, o);
        checks++; if (o.req_cnt !== 1 || o.req_first !== 2) begin errors++; $display("FAIL store.mem_req: got cnt=%0d first=%0d exp 1/2", o.req_cnt, o.req_first); end
        checks++; if (o.mwe !== 1'b1 || o.mwdata !== 16'h00FF || o.maddr !== 16'h0300) begin errors++; $display("FAIL store.mem_bus: got we=%b wdata=%h addr=%h exp 1/00ff/0300", o.mwe, o.mwdata, o.maddr); end
        checks++; if (o.done_cnt !== 1 || o.done_cyc !== 2) begin errors++; $display("FAIL store.done: got cnt=%0d cyc=%0d exp 1/2", o.done_cnt, o.done_cyc); end
        checks++; if (o.reg_cnt !== 0) begin errors++; $display("FAIL store.reg_we: got %0d exp 0", o.reg_cnt); end
        checks++; if (o.flags_end !== 3'b101 || o.busy_after !== 1'b0) begin errors++; $display("FAIL store.ignored_start: got flags=%b busy=%b exp 101/0", o.flags_end, o.busy_after); end
    endtask

    task automatic test_upper_imm_link;
        obs_t o;
        do_op(2'd0, 1'b0, 2'd0, 2'd2, 4'd1, 8'hA5, 16'h0, 16'h0, 16'h7777, 3'b000, 1, 16'h0, 1'b0, o);
        checks++; if (o.wdata !== 16'hA500 || o.reg_cyc !== 1) begin errors++; $display("FAIL upper_imm.wdata: got %h cyc=%0d exp a500/1", o.wdata, o.reg_cyc); end
        do_op(2'd0, 1'b0, 2'd0, 2'd3, 4'd15, 8'h5A, 16'h0020, 16'h0, 16'h7777, 3'b000, 1, 16'h0, 1'b0, o);
        checks++; if (o.wdata !== 16'h0020 || o.waddr !== 4'd15) begin errors++; $display("FAIL link.wdata: got %h/%h exp 0020/f", o.wdata, o.waddr); end
        do_op(2'd0, 1'b0, 2'd0, 2'd1, 4'd2, 8'h00, 16'h0, 16'h0, 16'h7777, 3'b000, 1, 16'h0, 1'b0, o);
        checks++; if (o.wdata !== mdr_m) begin errors++; $display("FAIL mdr_src.wdata: got %h exp %h", o.wdata, mdr_m); end
    endtask

    task automatic test_stray_ack;
        obs_t o;
        int   hits;
        hits = 0;
        @(posedge clk); #1 mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        for (int k = 0; k < 3; k++) begin
            #1 if (reg_we || done || busy || mem_req) hits++;
            @(posedge clk); #1 mem_ack = 1'b0;
        end
        checks++; if (hits !== 0) begin errors++; $display("FAIL stray_ack.activity: got %0d exp 0", hits); end
        do_op(2'd0, 1'b0, 2'd0, 2'd1, 4'd4, 8'h00, 16'h0, 16'h0, 16'h0, 3'b000, 1, 16'h0, 1'b0, o);
        checks++; if (o.wdata !== mdr_m) begin errors++; $display("FAIL stray_ack.mdr: got %h exp %h", o.wdata, mdr_m); end
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        start = 1'b1; c_dest = 2'd0; c_reg_src = 2'd0; c_wr_reg = 4'd7; alu_out = 16'h1111;
        @(posedge clk); #1;
        c_wr_reg = 4'd9; alu_out = 16'h9999;
        #1;
        checks++; if (reg_we !== 1'b1 || reg_wdata !== 16'h1111 || done !== 1'b1) begin errors++; $display("FAIL b2b.first: got we=%b data=%h done=%b exp 1/1111/1", reg_we, reg_wdata, done); end
        @(posedge clk); #1;
        c_wr_reg = 4'd8; alu_out = 16'h2222;
        #1;
        checks++; if (reg_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b.held_start: got we=%b done=%b busy=%b exp 0/0/0", reg_we, done, busy); end
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        checks++; if (reg_we !== 1'b1 || reg_waddr !== 4'd8 || reg_wdata !== 16'h2222 || done !== 1'b1) begin errors++; $display("FAIL b2b.second: got we=%b addr=%h data=%h done=%b exp 1/8/2222/1", reg_we, reg_waddr, reg_wdata, done); end
        @(posedge clk); #2;
        checks++; if (reg_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b.tail: got we=%b busy=%b exp 0/0", reg_we, busy); end
    endtask

    task automatic test_reset_mid_mem;
        int hits;
        hits = 0;
        @(posedge clk); #1;
        start = 1'b1; c_dest = 2'd3; c_mem_write = 1'b0; c_wr_reg = 4'd6; alu_out = 16'h0200;
        {alu_carry, alu_neg, alu_zero} = 3'b111;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0200) begin errors++; $display("FAIL rst_mem.before: got req=%b addr=%h exp 1/0200", mem_req, mem_addr); end
        @(posedge clk); #1 rst = 1'b0;
        #1;
        mdr_m = '0;
        checks++; if ({mem_req, mem_we, reg_we, pc_we, done, busy} !== 6'b0) begin errors++; $display("FAIL rst_mem.strobes: got %b exp 000000", {mem_req, mem_we, reg_we, pc_we, done, busy}); end
        checks++; if ({mem_addr, mem_wdata, reg_wdata, pc_next, reg_waddr, flags} !== 71'h0) begin errors++; $display("FAIL rst_mem.data: got %h exp 0", {mem_addr, mem_wdata, reg_wdata, pc_next, reg_waddr, flags}); end
        mem_ack = 1'b1; mem_rdata = 16'hCAFE;
        for (int k = 0; k < 3; k++) begin
            #1 if (reg_we || done) hits++;
            @(posedge clk); #1 mem_ack = 1'b0;
        end
        #1 if (reg_we || done) hits++;
        checks++; if (hits !== 0) begin errors++; $display("FAIL rst_mem.late_ack: got %0d exp 0", hits); end
    endtask

    task automatic test_random;
        obs_t o, e;
        logic [1:0]  dest, cond, src;
        logic        mw;
        logic [3:0]  wr;
        logic [7:0]  im;
        logic [15:0] pc, sd, alu, rdata;
        logic [2:0]  fl;
        int          delay;
        bit          extra;
        for (int i = 0; i < 40; i++) begin
            dest = 2'($urandom); cond = 2'($urandom); src = 2'($urandom); mw = 1'($urandom);
            wr = 4'($urandom); im = 8'($urandom); pc = 16'($urandom); sd = 16'($urandom);
            alu = 16'($urandom); rdata = 16'($urandom); fl = 3'($urandom);
            delay = $urandom_range(1, 4);
            extra = (dest == 2'd3) && ($urandom_range(0, 1) == 1);
            e = model(dest, mw, cond, src, wr, im, pc, sd, alu, fl, delay, rdata, mdr_m);
            do_op(dest, mw, cond, src, wr, im, pc, sd, alu, fl, delay, rdata, extra, o);
            if (dest == 2'd3 && !mw) mdr_m = rdata;
            checks++; if (o.reg_cnt !== e.reg_cnt || o.reg_cyc !== e.reg_cyc) begin errors++; $display("FAIL rand%0d.reg_we: got cnt=%0d cyc=%0d exp %0d/%0d", i, o.reg_cnt, o.reg_cyc, e.reg_cnt, e.reg_cyc); end
            if (e.reg_cnt == 1) begin
                checks++; if (o.waddr !== e.waddr || o.wdata !== e.wdata) begin errors++; $display("FAIL rand%0d.reg_data: got %h/%h exp %h/%h", i, o.waddr, o.wdata, e.waddr, e.wdata); end
            end
            checks++; if (o.pc_cnt !== e.pc_cnt || o.pc_cyc !== e.pc_cyc || o.pcv !== e.pcv) begin errors++; $display("FAIL rand%0d.pc: got %0d/%0d/%h exp %0d/%0d/%h", i, o.pc_cnt, o.pc_cyc, o.pcv, e.pc_cnt, e.pc_cyc, e.pcv); end
            checks++; if (o.done_cnt !== e.done_cnt || o.done_cyc !== e.done_cyc || o.busy_after !== 1'b0) begin errors++; $display("FAIL rand%0d.done: got %0d/%0d busy=%b exp %0d/%0d busy=0", i, o.done_cnt, o.done_cyc, o.busy_after, e.done_cnt, e.done_cyc); end
            checks++; if (o.req_cnt !== e.req_cnt || o.req_first !== e.req_first || o.req_unstable !== 1'b0) begin errors++; $display("FAIL rand%0d.mem_req: got %0d/%0d unstable=%b exp %0d/%0d", i, o.req_cnt, o.req_first, o.req_unstable, e.req_cnt, e.req_first); end
            if (e.req_cnt != 0) begin
                checks++; if (o.maddr !== e.maddr || o.mwe !== e.mwe || o.mwdata !== e.mwdata) begin errors++; $display("FAIL rand%0d.mem_bus: got %h/%b/%h exp %h/%b/%h", i, o.maddr, o.mwe, o.mwdata, e.maddr, e.mwe, e.mwdata); end
            end
            checks++; if (o.flags_end !== e.flags_end) begin errors++; $display("FAIL rand%0d.flags: got %b exp %b", i, o.flags_end, e.flags_end); end
        end
    endtask

    initial begin
        test_reset();
        test_reg_write();
        test_branch();
        test_load();
        test_store();
        test_upper_imm_link();
        test_stray_ack();
        test_back_to_back();
        test_reset_mid_mem();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
